// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: state codes, opcodes
// and the datapath select/operation encodings driven by the controller.
package riscv_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECR    = 4'd6;
  localparam state_t S_EXECI    = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_JALR     = 4'd9;
  localparam state_t S_JAL      = 4'd10;
  localparam state_t S_BRANCH   = 4'd11;
  localparam state_t S_LUI      = 4'd12;
  localparam state_t S_ERROR    = 4'd13;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011,
    ALU_XOR = 3'b100, ALU_SLT = 3'b101, ALU_SLTU = 3'b110
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10, RES_IMMEXT = 2'b11
  } result_src_e;

  typedef enum logic [1:0] {
    SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_A = 2'b10
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SRCB_B = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10
  } alu_src_b_e;

  function automatic logic [2:0] imm_src_for_op(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle; the datapath side is master, the controller slave.
interface multicycle_controller_if #(parameter int CNT_W = 32);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             Zero;
  logic             MemReady;
  logic             PCWrite;
  logic             AdrSrc;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUControl;
  logic [2:0]       ImmSrc;
  logic             Illegal;
  logic [CNT_W-1:0] InstRetired;

  modport master (
    output op, funct3, funct7, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal, InstRetired
  );

  modport slave (
    input  op, funct3, funct7, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal, InstRetired
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps funct3/funct7[5] to an ALU operation; shifts are flagged unsupported.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic       i_is_rtype,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output logic [2:0] o_alu_control,
  output logic       o_unsupported
);

  // funct3 decode; funct7[5] only selects sub for register-register ops
  always_comb begin
    o_alu_control = ALU_ADD;
    o_unsupported = 1'b0;
    case (i_funct3)
      3'b000: begin
        if (i_is_rtype && i_funct7_5) o_alu_control = ALU_SUB;
        else                          o_alu_control = ALU_ADD;
      end
      3'b111:  o_alu_control = ALU_AND;
      3'b110:  o_alu_control = ALU_OR;
      3'b100:  o_alu_control = ALU_XOR;
      3'b010:  o_alu_control = ALU_SLT;
      3'b011:  o_alu_control = ALU_SLTU;
      default: begin
        o_alu_control = ALU_ADD;
        o_unsupported = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: Moore-decoded datapath controls, sticky
// illegal-instruction flag and a retired-instruction counter.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.slave bus
);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_illegal;
  logic [CNT_W-1:0] r_inst_retired;
  logic             w_pc_write, w_adr_src, w_mem_write, w_ir_write, w_reg_write;
  logic [1:0]       w_result_src, w_alu_src_a, w_alu_src_b;
  logic [2:0]       w_alu_control, w_imm_src, w_funct_alu;
  logic             w_funct_bad, w_is_rtype;

  assign w_is_rtype = (r_state == S_EXECR);

  alu_decoder u_alu_decoder (
    .i_is_rtype    (w_is_rtype),
    .i_funct3      (bus.funct3),
    .i_funct7_5    (bus.funct7[5]),
    .o_alu_control (w_funct_alu),
    .o_unsupported (w_funct_bad)
  );

  // Next-state and per-state control decode
  always_comb begin
    w_next_state  = r_state;
    w_pc_write    = 1'b0;
    w_adr_src     = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_result_src  = RES_ALUOUT;
    w_alu_src_a   = SRCA_PC;
    w_alu_src_b   = SRCB_B;
    w_alu_control = ALU_ADD;
    w_imm_src     = IMM_I;
    case (r_state)
      S_FETCH: begin
        w_alu_src_b  = SRCB_FOUR;
        w_result_src = RES_ALURESULT;
        w_ir_write   = bus.MemReady;
        w_pc_write   = bus.MemReady;
        if (bus.MemReady) w_next_state = S_DECODE;
        else              w_next_state = S_FETCH;
      end
      S_DECODE: begin
        w_alu_src_a = SRCA_OLDPC;
        w_alu_src_b = SRCB_IMM;
        w_imm_src   = imm_src_for_op(bus.op);
        case (bus.op)
          OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
          OP_RTYPE:          w_next_state = S_EXECR;
          OP_ITYPE:          w_next_state = S_EXECI;
          OP_BRANCH:         w_next_state = S_BRANCH;
          OP_JAL:            w_next_state = S_JAL;
          OP_JALR:           w_next_state = S_JALR;
          OP_LUI:            w_next_state = S_LUI;
          default:           w_next_state = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = SRCA_A;
        w_alu_src_b = SRCB_IMM;
        if (bus.op == OP_STORE) begin
          w_imm_src    = IMM_S;
          w_next_state = S_MEMWRITE;
        end else begin
          w_imm_src    = IMM_I;
          w_next_state = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
        if (bus.MemReady) w_next_state = S_MEMWB;
        else              w_next_state = S_MEMREAD;
      end
      S_MEMWB: begin
        w_result_src = RES_DATA;
        w_reg_write  = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        if (bus.MemReady) w_next_state = S_FETCH;
        else              w_next_state = S_MEMWRITE;
      end
      S_EXECR, S_EXECI: begin
        w_alu_src_a   = SRCA_A;
        w_alu_src_b   = (r_state == S_EXECI) ? SRCB_IMM : SRCB_B;
        w_alu_control = w_funct_alu;
        if (w_funct_bad) w_next_state = S_ERROR;
        else             w_next_state = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_next_state = S_FETCH;
      end
      S_JALR: begin
        w_alu_src_a  = SRCA_A;
        w_alu_src_b  = SRCB_IMM;
        w_next_state = S_JAL;
      end
      S_JAL: begin
        // ALUOut already holds the target; ALU computes the link value OldPC+4
        w_alu_src_a  = SRCA_OLDPC;
        w_alu_src_b  = SRCB_FOUR;
        w_pc_write   = 1'b1;
        w_next_state = S_ALUWB;
      end
      S_BRANCH: begin
        w_alu_src_a  = SRCA_A;
        w_next_state = S_FETCH;
        case (bus.funct3)
          3'b000: begin w_alu_control = ALU_SUB; w_pc_write = bus.Zero;  end
          3'b001: begin w_alu_control = ALU_SUB; w_pc_write = ~bus.Zero; end
          3'b100: begin w_alu_control = ALU_SLT; w_pc_write = ~bus.Zero; end
          3'b101: begin w_alu_control = ALU_SLT; w_pc_write = bus.Zero;  end
          default: w_next_state = S_ERROR;
        endcase
      end
      S_LUI: begin
        w_imm_src    = IMM_U;
        w_result_src = RES_IMMEXT;
        w_reg_write  = 1'b1;
        w_next_state = S_FETCH;
      end
      S_ERROR: w_next_state = S_ERROR;
      default: w_next_state = S_ERROR;
    endcase
  end

  // State, sticky illegal flag and retire counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_FETCH;
      r_illegal      <= 1'b0;
      r_inst_retired <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state == S_ERROR) r_illegal <= 1'b1;
      else                         r_illegal <= r_illegal;
      if ((w_next_state == S_FETCH) && (r_state != S_FETCH) && (r_state != S_ERROR))
        r_inst_retired <= r_inst_retired + {{(CNT_W-1){1'b0}}, 1'b1};
      else
        r_inst_retired <= r_inst_retired;
    end
  end

  assign bus.PCWrite     = w_pc_write  & rst;
  assign bus.IRWrite     = w_ir_write  & rst;
  assign bus.RegWrite    = w_reg_write & rst;
  assign bus.MemWrite    = w_mem_write & rst;
  assign bus.AdrSrc      = w_adr_src;
  assign bus.ResultSrc   = w_result_src;
  assign bus.ALUSrcA     = w_alu_src_a;
  assign bus.ALUSrcB     = w_alu_src_b;
  assign bus.ALUControl  = w_alu_control;
  assign bus.ImmSrc      = w_imm_src;
  assign bus.Illegal     = r_illegal;
  assign bus.InstRetired = r_inst_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench: each driven cycle queues its expected controls, and a
// negedge monitor pops and compares them against the controller outputs.
module tb_multicycle_controller;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  multicycle_controller_if #(.CNT_W(CNT_W)) bus ();

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [17:0]      ctl;
    logic [CNT_W-1:0] ret;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic       t_rst = 1'b0;
  logic [6:0] t_op  = 7'd0;
  logic [2:0] t_f3  = 3'd0;
  logic [6:0] t_f7  = 7'd0;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] JR  = 7'b1100111;
  localparam logic [6:0] LU  = 7'b0110111;
  localparam logic [6:0] BAD = 7'b1111111;

  task automatic set_in(input logic r, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    t_rst = r;
    t_op  = op;
    t_f3  = f3;
    t_f7  = f7;
  endtask

  // en = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite}
  task automatic cyc(input string name, input logic mr, input logic z, input logic [4:0] en,
                     input logic [1:0] res, input logic [1:0] a, input logic [1:0] b,
                     input logic [2:0] alu, input logic [2:0] imm, input logic ill,
                     input logic [31:0] ret);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = t_rst;
    bus.op       = t_op;
    bus.funct3   = t_f3;
    bus.funct7   = t_f7;
    bus.MemReady = mr;
    bus.Zero     = z;
    e.name = name;
    e.ctl  = {en, res, a, b, alu, imm, ill};
    e.ret  = ret;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [17:0] act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
             bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.Illegal};
      n_tests++;
      if (act !== e.ctl || bus.InstRetired !== e.ret) begin
        n_fail++;
        $display("FAIL %s: got ctl=%b ret=%0d, expected ctl=%b ret=%0d",
                 e.name, act, bus.InstRetired, e.ctl, e.ret);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7 = 7'd0; bus.Zero = 1'b0; bus.MemReady = 1'b0;

    // reset gating, fetch wait, R-type sub
    set_in(1'b0, RT, 3'b000, 7'b0100000);
    cyc("reset_gate",  1'b1, 1'b0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 32'd0);
    set_in(1'b1, RT, 3'b000, 7'b0100000);
    for (int i = 0; i < 3; i++)
      cyc("fetch_wait", 1'b0, 1'b0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 32'd0);
    cyc("fetch_go",    1'b1, 1'b0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 32'd0);
    cyc("r_decode",    1'b0, 1'b0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 1'b0, 32'd0);
    cyc("r_execr_sub", 1'b0, 1'b0, 5'b00000, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 1'b0, 32'd0);
    cyc("r_aluwb",     1'b0, 1'b0, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 32'd0);

    // lw with two stalled MEMREAD cycles
    set_in(1'b1, LW, 3'b010, 7'd0);
    cyc("lw_fetch",    1'b1, 1'b0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 32'd1);
    cyc("lw_decode",   1'b0, 1'b0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 1'b0, 32'd1);
    cyc("lw_memadr",   1'b0, 1'b0, 5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 1'b0, 32'd1);
    cyc("lw_memrd0",   1'b0, 1'b0, 5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 32'd1);
    cyc("lw_memrd1",   1'b0, 1'b0, 5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 32'd1);
    cyc("lw_memrd2",   1'b1, 1'b0, 5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 32'd1);
    cyc("lw_memwb",    1'b0, 1'b0, 5'b00001, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 32'd1);

    // bne with Zero=1 (not taken) then Zero=0 (taken)
    set_in(1'b1, BR, 3'b001, 7'd0);
    cyc("bne_fetch",   1'b1, 1'b0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 32'd2);
    cyc("bne_decode",  1'b0, 1'b0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b010, 1'b0, 32'd2);
    cyc("bne_z1",      1'b0, 1'b1, 5'b00000, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 1'b0, 32'd2);
    cyc("bne_fetch2",  1'b1, 1'b0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 32'd3);
    cyc("bne_decode2", 1'b0, 1'b0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b010, 1'b0, 32'd3);
    cyc("bne_z0",      1'b0, 1'b0, 5'b10000, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 1'b0, 32'd3);

    // sw with one stalled MEMWRITE cycle
    set_in(1'b1, SW, 3'b010, 7'd0);
    cyc("sw_fetch",    1'b1, 1'b0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 32'd4);
    cyc("sw_decode",   1'b0, 1'b0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b001, 1'b0, 32'd4);
    cyc("sw_memadr",   1'b0, 1'b0, 5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 1'b0, 32'd4);
    cyc("sw_memwr0",   1'b0, 1'b0, 5'b01100, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 32'd4);
    cyc("sw_memwr1",   1'b1, 1'b0, 5'b01100, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 32'd4);

    // lui
    set_in(1'b1, LU, 3'b000, 7'd0);
    cyc("lui_fetch",   1'b1, 1'b0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 32'd5);
    cyc("lui_decode",  1'b0, 1'b0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b100, 1'b0, 32'd5);
    cyc("lui_wb",      1'b0, 1'b0, 5'b00001, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100, 1'b0, 32'd5);

    // jal
    set_in(1'b1, JL, 3'b000, 7'd0);
    cyc("jal_fetch",   1'b1, 1'b0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 32'd6);
    cyc("jal_decode",  1'b0, 1'b0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b011, 1'b0, 32'd6);
    cyc("jal_jal",     1'b0, 1'b0, 5'b10000, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 1'b0, 32'd6);
    cyc("jal_aluwb",   1'b0, 1'b0, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 32'd6);

    // jalr
    set_in(1'b1, JR, 3'b000, 7'd0);
    cyc("jalr_fetch",  1'b1, 1'b0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 32'd7);
    cyc("jalr_decode", 1'b0, 1'b0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 1'b0, 32'd7);
    cyc("jalr_jalr",   1'b0, 1'b0, 5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 1'b0, 32'd7);
    cyc("jalr_jal",    1'b0, 1'b0, 5'b10000, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 1'b0, 32'd7);
    cyc("jalr_aluwb",  1'b0, 1'b0, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 32'd7);

    // addi with funct7[5]=1 must stay add
    set_in(1'b1, IT, 3'b000, 7'b0100000);
    cyc("addi_fetch",  1'b1, 1'b0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 32'd8);
    cyc("addi_decode", 1'b0, 1'b0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 1'b0, 32'd8);
    cyc("addi_execi",  1'b0, 1'b0, 5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 1'b0, 32'd8);
    cyc("addi_aluwb",  1'b0, 1'b0, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 32'd8);

    // andi
    set_in(1'b1, IT, 3'b111, 7'd0);
    cyc("andi_fetch",  1'b1, 1'b0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 32'd9);
    cyc("andi_decode", 1'b0, 1'b0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 1'b0, 32'd9);
    cyc("andi_execi",  1'b0, 1'b0, 5'b00000, 2'b00, 2'b10, 2'b01, 3'b010, 3'b000, 1'b0, 32'd9);
    cyc("andi_aluwb",  1'b0, 1'b0, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 32'd9);

    // bge taken on Zero=1
    set_in(1'b1, BR, 3'b101, 7'd0);
    cyc("bge_fetch",   1'b1, 1'b0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 32'd10);
    cyc("bge_decode",  1'b0, 1'b0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b010, 1'b0, 32'd10);
    cyc("bge_z1",      1'b0, 1'b1, 5'b10000, 2'b00, 2'b10, 2'b00, 3'b101, 3'b000, 1'b0, 32'd10);

    // R-type or
    set_in(1'b1, RT, 3'b110, 7'd0);
    cyc("or_fetch",    1'b1, 1'b0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 32'd11);
    cyc("or_decode",   1'b0, 1'b0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 1'b0, 32'd11);
    cyc("or_execr",    1'b0, 1'b0, 5'b00000, 2'b00, 2'b10, 2'b00, 3'b011, 3'b000, 1'b0, 32'd11);
    cyc("or_aluwb",    1'b0, 1'b0, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 32'd11);

    // reset asserted mid-MEMWRITE with MemReady=1
    set_in(1'b1, SW, 3'b010, 7'd0);
    cyc("sw2_fetch",   1'b1, 1'b0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 32'd12);
    cyc("sw2_decode",  1'b0, 1'b0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b001, 1'b0, 32'd12);
    cyc("sw2_memadr",  1'b0, 1'b0, 5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 1'b0, 32'd12);
    cyc("sw2_memwr",   1'b0, 1'b0, 5'b01100, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 32'd12);
    set_in(1'b0, SW, 3'b010, 7'd0);
    cyc("rst_mid_memwrite", 1'b1, 1'b0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 32'd0);

    // illegal opcode: ERROR is sticky, no writes, counter frozen
    set_in(1'b1, BAD, 3'b000, 7'd0);
    cyc("rst_release", 1'b0, 1'b0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 32'd0);
    cyc("ill_fetch",   1'b1, 1'b0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 32'd0);
    cyc("ill_decode",  1'b0, 1'b0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 1'b0, 32'd0);
    for (int i = 0; i < 10; i++)
      cyc("ill_error", 1'b1, i[0], 5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1, 32'd0);

    // shift in EXECR -> ERROR without register write
    set_in(1'b0, RT, 3'b001, 7'd0);
    cyc("rst_clear",   1'b1, 1'b0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 32'd0);
    set_in(1'b1, RT, 3'b001, 7'd0);
    cyc("sll_fetch",   1'b1, 1'b0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 32'd0);
    cyc("sll_decode",  1'b0, 1'b0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 1'b0, 32'd0);
    cyc("sll_execr",   1'b0, 1'b0, 5'b00000, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 1'b0, 32'd0);
    cyc("sll_error",   1'b1, 1'b0, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1, 32'd0);

    // unsupported branch funct3 -> ERROR with PCWrite=0
    set_in(1'b0, BR, 3'b010, 7'd0);
    cyc("rst_clear2",  1'b1, 1'b0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 32'd0);
    set_in(1'b1, BR, 3'b010, 7'd0);
    cyc("bx_fetch",    1'b1, 1'b0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 32'd0);
    cyc("bx_decode",   1'b0, 1'b0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b010, 1'b0, 32'd0);
    cyc("bx_branch",   1'b0, 1'b1, 5'b00000, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 1'b0, 32'd0);
    cyc("bx_error",    1'b1, 1'b1, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1, 32'd0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle RV32I datapath: one shared ALU, one unified memory, IR/OldPC/A/B/ALUOut/Data registers.
- Sequences fetch, decode, execute, memory and writeback.
- Drives every datapath enable and mux select from op/funct3/funct7/Zero, with a memory-ready handshake.
- Reports illegal opcodes and keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of the InstRetired counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
op  input  7  Instr[6:0] from IR
funct3  input  3  Instr[14:12]
funct7  input  7  Instr[31:25]
Zero  input  1  ALU zero flag, same cycle
MemReady  input  1  memory completes the current access this cycle
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
MemWrite  output  1  memory write request
IRWrite  output  1  IR and OldPC enable
RegWrite  output  1  register file write enable
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult, 11=ImmExt
ALUSrcA  output  2  00=PC, 01=OldPC, 10=A
ALUSrcB  output  2  00=B, 01=ImmExt, 10=constant 4
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu
ImmSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U
Illegal  output  1  sticky; an unsupported instruction was decoded
InstRetired  output  CNT_W  count of completed instructions

Behaviour:
- Reset:
  - rst low asynchronously forces state FETCH, Illegal=0, InstRetired=0.
  - While rst is low, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0.
- Outputs are Moore-decoded from state, except that PCWrite/IRWrite are gated by MemReady (FETCH) and PCWrite by Zero (BRANCH).
- Any output not listed for a state is 0. ALUControl defaults to add.
- States and behaviour:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite=PCWrite=MemReady. Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/JAL target into ALUOut). ImmSrc taken from op. Next state by op:
    - 0000011 (lw) / 0100011 (sw) -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - other -> ERROR
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc I for lw and S for sw. Goes to MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD: AdrSrc=1. Holds until MemReady, then MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
  - MEMWRITE: AdrSrc=1, MemWrite=1, held until MemReady. Goes to FETCH on the MemReady cycle.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl from funct decode, then ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc I, funct decode with funct7 ignored (no sub), then ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
  - JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc I, add, then JAL.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ALUWB (writes OldPC+4).
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ResultSrc=00, then FETCH. ALUControl and PCWrite by funct3:
    - 000 beq: sub, PCWrite=Zero
    - 001 bne: sub, PCWrite=~Zero
    - 100 blt: slt, PCWrite=~Zero
    - 101 bge: slt, PCWrite=Zero
    - other funct3 -> ERROR instead of FETCH, PCWrite=0
  - LUI: ImmSrc U, ResultSrc=11, RegWrite=1, then FETCH.
  - ERROR: all enables 0, Illegal=1. Stays in ERROR until reset.
- Funct decode:
  - 000 -> add, or sub when R-type and funct7[5]=1
  - 111 and, 110 or, 100 xor, 010 slt, 011 sltu
  - 001/101 (shifts) -> ERROR at the execute state with no register write
- InstRetired:
  - Increments by 1 on every transition into FETCH from a non-FETCH state.
  - Wraps modulo 2^CNT_W.
  - Never increments from ERROR.
- Reset mid-instruction abandons it with no count and no further writes.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum
  - opcode constants
  - ALUControl, ImmSrc, ResultSrc, ALUSrcA and ALUSrcB encodings
- One sub-module, alu_decoder: (isRtype, funct3, funct7[5]) -> ALUControl plus an unsupported flag.

Test Plan:
- Reset low mid-MEMWRITE, MemReady=1 -> MemWrite=0 immediately; state FETCH, InstRetired=0 after release.
- FETCH with MemReady=0 for 3 cycles then 1 -> IRWrite/PCWrite pulse exactly once on the 4th cycle, then DECODE.
- op=0110011, funct3=000, funct7=0100000 -> DECODE, EXECR (ALUControl=001), ALUWB (RegWrite=1, ResultSrc=00); InstRetired +1.
- op=0000011 with MemReady held low 2 cycles in MEMREAD -> states FETCH, DECODE, MEMADR, MEMREAD x3, MEMWB; RegWrite=1, ResultSrc=01 only in MEMWB.
- op=1100011, funct3=001, Zero=1 -> PCWrite=0 in BRANCH; repeat with Zero=0 -> PCWrite=1, ALUControl=001.
- op=1111111 -> ERROR, Illegal=1; every write enable stays 0 for 10 cycles; InstRetired frozen.
